// File: rtl/fire7_ofm_writer_pkg.sv
// Shared types and sizing helpers for the fire7 output-feature-map writer.
// State encoding plus default-geometry word/pixel counts.
package fire7_ofm_writer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DSP_NO_DEF = 192;
    localparam int LANES_DEF  = 4;
    localparam int WOUT_DEF   = 16;

    localparam int WORDS_PER_PIX = DSP_NO_DEF / LANES_DEF;
    localparam int PIX_TOTAL     = WOUT_DEF ** 2;

    function automatic int words_per_pix(input int dsp_no, input int lanes);
        return dsp_no / lanes;
    endfunction

    function automatic int pix_total(input int wout);
        return wout * wout;
    endfunction

endpackage

// File: rtl/fire7_ofm_writer.sv
// Packs per-pixel channel results into RAM words and streams them out.
// Optional sticky overflow flag for dropped samples: FIRE7_OFM_WRITER_OVF_EN.
module fire7_ofm_writer
    import fire7_ofm_writer_pkg::*;
#(
    parameter int DSP_NO = 192,
    parameter int WIDTH  = 16,
    parameter int WOUT   = 16,
    parameter int LANES  = 4,
    localparam int WORDS  = words_per_pix(DSP_NO, LANES),
    localparam int PIX    = pix_total(WOUT),
    localparam int ADDR_W = $clog2(PIX * WORDS),
    localparam int WORD_BITS = WIDTH * LANES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fire7_expand1_sample,
    input  logic [WIDTH-1:0]     ofm [DSP_NO],
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [WORD_BITS-1:0] wr_data,
    output logic                 ram_feedback,
    output logic                 busy
`ifdef FIRE7_OFM_WRITER_OVF_EN
    ,
    output logic                 overflow
`endif
);

    localparam int PIX_W  = (PIX > 1) ? $clog2(PIX) : 1;
    localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t               state;
    logic [PIX_W-1:0]     pixel_cnt;
    logic [WORD_W-1:0]    word_cnt;
    logic [WORD_W-1:0]    nxt_word;
    logic [WORD_BITS-1:0] shadow [WORDS];
    logic [WORD_BITS-1:0] word0;
    logic [ADDR_W-1:0]    pix_base;
    logic                 last_word;
    logic                 last_pix;
    logic                 cap;

    assign nxt_word  = word_cnt + WORD_W'(1);
    assign last_word = (word_cnt == WORD_W'(WORDS - 1));
    assign last_pix  = (pixel_cnt == PIX_W'(PIX - 1));
    assign pix_base  = ADDR_W'(pixel_cnt) * ADDR_W'(WORDS);
    assign busy      = (state == WRITE);

    // a sample is taken from IDLE, or in the final WRITE cycle unless the layer ends
    assign cap = fire7_expand1_sample &&
                 ((state == IDLE) ||
                  ((state == WRITE) && last_word && !last_pix));

    // word 0 goes straight from the live inputs on the capture edge
    always_comb begin
        word0 = '0;
        for (int j = 0; j < LANES; j++) begin
            word0[j*WIDTH +: WIDTH] = ofm[j];
        end
    end

    // shadow bank holds the captured pixel for words 1..WORDS-1
    always_ff @(posedge clk) begin
        if (cap) begin
            for (int k = 0; k < WORDS; k++) begin
                for (int j = 0; j < LANES; j++) begin
                    shadow[k][j*WIDTH +: WIDTH] <= ofm[k*LANES + j];
                end
            end
        end
    end

    // control FSM with registered write port and layer-done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pixel_cnt    <= '0;
            word_cnt     <= '0;
            wr_en        <= 1'b0;
            ram_feedback <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
        end else begin
            ram_feedback <= 1'b0;
            unique case (state)
                IDLE: begin
                    wr_en <= 1'b0;
                    if (fire7_expand1_sample) begin
                        state    <= WRITE;
                        word_cnt <= '0;
                        wr_en    <= 1'b1;
                        wr_addr  <= pix_base;
                        wr_data  <= word0;
                    end
                end
                WRITE: begin
                    if (!last_word) begin
                        word_cnt <= nxt_word;
                        wr_addr  <= wr_addr + ADDR_W'(1);
                        wr_data  <= shadow[nxt_word];
                    end else if (last_pix) begin
                        state        <= DONE;
                        wr_en        <= 1'b0;
                        ram_feedback <= 1'b1;
                        word_cnt     <= '0;
                    end else begin
                        pixel_cnt <= pixel_cnt + PIX_W'(1);
                        word_cnt  <= '0;
                        if (fire7_expand1_sample) begin
                            wr_addr <= wr_addr + ADDR_W'(1);
                            wr_data <= word0;
                        end else begin
                            state <= IDLE;
                            wr_en <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    wr_en <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    wr_en <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIRE7_OFM_WRITER_OVF_EN
    logic drop;

    assign drop = fire7_expand1_sample && (state == WRITE) && !last_word;

    // sticky flag for a sample lost mid-write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fire7_ofm_writer.sv
// Scoreboard bench for fire7_ofm_writer at default geometry.
// Stimulus queues expected words; a negedge monitor checks them.
module tb_fire7_ofm_writer;

    localparam int DSP_NO = 192;
    localparam int WIDTH  = 16;
    localparam int LANES  = 4;
    localparam int WORDS  = 48;
    localparam int NPIX   = 256;

    typedef struct {
        logic [13:0] a;
        logic [63:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample;
    logic [15:0] ofm_drv [DSP_NO];
    logic        wr_en;
    logic [13:0] wr_addr;
    logic [63:0] wr_data;
    logic        ram_feedback;
    logic        busy;
`ifdef FIRE7_OFM_WRITER_OVF_EN
    logic        overflow;
`endif

    logic [15:0] m [DSP_NO];
    exp_t        q [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc = 0;
    int          phase = 0;
    int          busy_cnt = 0;
    int          wr_total = 0;
    int          fb_cnt = 0;
    int          last_wr_cyc = -10;
    logic [13:0] last_addr = '0;

    fire7_ofm_writer dut (
        .clk                  (clk),
        .rst                  (rst),
        .fire7_expand1_sample (sample),
        .ofm                  (ofm_drv),
        .wr_en                (wr_en),
        .wr_addr              (wr_addr),
        .wr_data              (wr_data),
        .ram_feedback         (ram_feedback),
        .busy                 (busy)
`ifdef FIRE7_OFM_WRITER_OVF_EN
        ,
        .overflow             (overflow)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_ofm(input int base);
        for (int c = 0; c < DSP_NO; c++) begin
            m[c]       = 16'(base + c);
            ofm_drv[c] = 16'(base + c);
        end
    endtask

    task automatic push_pix(input int p, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.a = 14'(p * WORDS + k);
            for (int j = 0; j < LANES; j++) begin
                e.d[j*WIDTH +: WIDTH] = m[k*LANES + j];
            end
            q.push_back(e);
        end
    endtask

    task automatic pulse();
        sample = 1'b1;
        @(posedge clk);
        #1 sample = 1'b0;
    endtask

    // monitor: pop and compare every write, check the layer-done pulse
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (busy) busy_cnt++;
            if (wr_en) begin
                wr_total++;
                if (phase == 1 && wr_addr == 14'd48)
                    chk("no_gap_47_48", 64'(last_wr_cyc), 64'(cyc - 1));
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0h expected none",
                             wr_addr);
                end else begin
                    e = q.pop_front();
                    chk("wr_addr", 64'(wr_addr), 64'(e.a));
                    chk("wr_data", wr_data, e.d);
                end
                last_wr_cyc = cyc;
                last_addr   = wr_addr;
            end
            if (ram_feedback) begin
                fb_cnt++;
                chk("fb_after_last", 64'(last_wr_cyc), 64'(cyc - 1));
                chk("fb_last_addr", 64'(last_addr), 64'd12287);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst    = 1'b1;
        sample = 1'b0;
        set_ofm(0);
        #12;
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", wr_data, 64'd0);
        chk("rst_fb", 64'(ram_feedback), 64'd0);
`ifdef FIRE7_OFM_WRITER_OVF_EN
        chk("rst_ovf", 64'(overflow), 64'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // pixel 0 from IDLE, pixel 1 sampled on pixel 0's final cycle
        phase    = 1;
        busy_cnt = 0;
        wr_total = 0;
        set_ofm(0);
        push_pix(0, WORDS);
        pulse();
        @(negedge clk);
        chk("word0_hand", wr_data, 64'h0003_0002_0001_0000);
        chk("word0_addr", 64'(wr_addr), 64'd0);
        @(posedge clk);
        #1;
        repeat (46) @(posedge clk);
        #1;
        set_ofm(1000);
        push_pix(1, WORDS);
        pulse();
        repeat (60) @(posedge clk);
        #1;
        chk("b2b_busy_cycles", 64'(busy_cnt), 64'd96);
        chk("b2b_writes", 64'(wr_total), 64'd96);
        chk("b2b_q_empty", 64'(q.size()), 64'd0);
        chk("b2b_no_fb", 64'(fb_cnt), 64'd0);

        // pixel 2 with a sample 10 cycles in that must be dropped
        phase = 2;
        set_ofm(16'hA000);
        push_pix(2, WORDS);
        pulse();
`ifdef FIRE7_OFM_WRITER_OVF_EN
        chk("ovf_before_drop", 64'(overflow), 64'd0);
`endif
        repeat (9) @(posedge clk);
        #1;
        for (int c = 0; c < DSP_NO; c++) ofm_drv[c] = 16'h5555;
        pulse();
`ifdef FIRE7_OFM_WRITER_OVF_EN
        chk("ovf_after_drop", 64'(overflow), 64'd1);
`endif
        repeat (60) @(posedge clk);
        #1;
        chk("drop_q_empty", 64'(q.size()), 64'd0);
        chk("drop_idle", 64'(busy), 64'd0);
`ifdef FIRE7_OFM_WRITER_OVF_EN
        chk("ovf_sticky", 64'(overflow), 64'd1);
`endif

        // pixel 3 aborted by reset at word 20
        phase = 3;
        set_ofm(16'h3000);
        push_pix(3, 20);
        pulse();
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_wr_en", 64'(wr_en), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_addr", 64'(wr_addr), 64'd0);
        chk("abort_data", wr_data, 64'd0);
`ifdef FIRE7_OFM_WRITER_OVF_EN
        chk("abort_ovf", 64'(overflow), 64'd0);
`endif
        @(negedge clk);
        chk("abort_q_empty", 64'(q.size()), 64'd0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // full layer at a 65-cycle cadence, starting again at address 0
        phase    = 4;
        wr_total = 0;
        for (int p = 0; p < NPIX; p++) begin
            set_ofm((p * 193) & 16'hFFFF);
            push_pix(p, WORDS);
            pulse();
            repeat (64) @(posedge clk);
            #1;
        end
        chk("layer_writes", 64'(wr_total), 64'd12288);
        chk("layer_fb_count", 64'(fb_cnt), 64'd1);
        chk("layer_last_addr", 64'(last_addr), 64'd12287);
        chk("layer_q_empty", 64'(q.size()), 64'd0);
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_wr_en", 64'(wr_en), 64'd0);

        // sample while DONE is ignored
        phase = 5;
        set_ofm(16'h7777);
        pulse();
        repeat (60) @(posedge clk);
        #1;
        chk("done_no_write", 64'(wr_total), 64'd12288);
        chk("done_no_fb", 64'(fb_cnt), 64'd1);
        chk("done_still_idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
